tx_report_arbiter: RTL and testbench
====================================

TX_REPORT_ARBITER -- requirements
Module: tx_report_arbiter

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 9, giving the hex digits per message (word width W = 4*NIBBLES).
REQ-002 The block SHALL have port `clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port `req_valid`, input, 3 bits: one-cycle strobe per source (0=result, 1=iowrite, 2=gc).
REQ-005 The block SHALL have port `req_word`, input, 3*W bits: source i word at [W*i+W-1 : W*i], sampled with its strobe.
REQ-006 The block SHALL have port `req_pending`, output, 3 bits: source i holds an untransmitted word.
REQ-007 The block SHALL have port `drop_count`, output, 8 bits: saturating count of strobes lost to overflow.
REQ-008 The block SHALL have port `tx_data`, output, 8 bits: ASCII byte offered to the UART transmitter.
REQ-009 The block SHALL have port `tx_we`, output, 1 bit: the byte on `tx_data` is valid.
REQ-010 The block SHALL have port `tx_busy`, input, 1 bit: the transmitter cannot accept a byte.
REQ-011 The block SHALL have port `idle`, output, 1 bit: high when in IDLE with no source pending.

Function
REQ-012 The block SHALL capture a strobe when `req_valid[i]` is high and `req_pending[i]` is low: set pending, latch the word.
REQ-013 The block SHALL drop a strobe arriving while pending[i] is set and not cleared that cycle, and increment `drop_count`, saturating at 255.
REQ-014 The block SHALL capture a strobe that coincides with the grant clearing pending[i]; pending[i] stays 1 and the new word is held.
REQ-015 The block SHALL use states IDLE, TAG, HEX, CR and LF.
REQ-016 In IDLE, when any source is pending, the block SHALL grant round-robin starting at last_grant+1 (mod 3), in one cycle.
REQ-017 On a grant, the block SHALL load the shift register, clear pending[g], update last_grant, and enter TAG.
REQ-018 The block SHALL hold `tx_we` high in TAG, HEX, CR and LF, and low in IDLE.
REQ-019 A byte SHALL be accepted on a rising edge with `tx_we` high and `tx_busy` low; only then may the state or digit advance.
REQ-020 While a byte is unaccepted, `tx_data` and `tx_we` SHALL stay stable.
REQ-021 The TAG byte SHALL be 0x52 'R', 0x57 'W' or 0x47 'G' for source 0, 1 or 2; TAG then goes to HEX.
REQ-022 HEX SHALL send NIBBLES digits, MSB nibble first, using the codes below, with a left shift by 4 on each acceptance.
  - nibble < 10 -> nibble + 48
  - otherwise -> nibble + 55 (uppercase)
REQ-023 After the last digit, CR sends 0x0D and goes to LF; LF sends 0x0A and goes to IDLE.
REQ-024 Latency with `tx_busy` held low:
  - strobe sampled at edge E0;
  - grant at E1;
  - TAG accepted at E2;
  - NIBBLES+3 bytes accepted on consecutive edges;
  - IDLE for at least one cycle before the next grant.

Reset
REQ-025 While `reset_n` is low, the block SHALL force, asynchronously:
  - state = IDLE; `tx_we` = 0; `tx_data` = 0x00;
  - `req_pending` = 0; `drop_count` = 0;
  - last_grant = 2 (so source 0 wins first); `idle` = 1.
REQ-026 A reset mid-message SHALL abandon the partial line without sending CR/LF; `tx_we` SHALL fall immediately.

Structure
REQ-027 A shared package SHALL hold the constants below; widths derive from NIBBLES.
  - tag characters, CR/LF codes
  - NIBBLES default
  - state encoding
REQ-028 Round-robin selection SHALL be a sub-module `rr_arbiter3`: pending[2:0] and last_grant in, one-hot grant out, combinational.
REQ-029 Nibble-to-ASCII conversion SHALL stay inline; no further sub-modules.

Verification
REQ-030 Source 0 word 0x000002A3F with busy low SHALL emit 52 30 30 30 30 30 32 41 33 46 0D 0A, one byte per cycle, then `idle` = 1.
REQ-031 With `tx_busy` held high 5 cycles during HEX, `tx_data` and `tx_we` SHALL stay constant, no digit SHALL be skipped, and the sequence SHALL resume intact.
REQ-032 All three strobes in one cycle after reset SHALL emit lines tagged R, W, G in order; drop_count = 0.
REQ-033 Two source-1 strobes while pending SHALL give drop_count = 1; 300 overflowing strobes SHALL leave drop_count = 255.
REQ-034 A source-2 strobe on its own grant edge SHALL be held, and two G lines SHALL be emitted.
REQ-035 `reset_n` low mid-HEX SHALL drop `tx_we` at once and clear pending; a later strobe SHALL emit a full line starting at TAG.

Source files
------------

// File: rtl/tx_report_arbiter_pkg.sv
// tx_report_arbiter_pkg: shared constants and state encoding for the report arbiter
package tx_report_arbiter_pkg;
  localparam int NIBBLES_DEF = 9;
  localparam logic [7:0] TAG_R = 8'h52;
  localparam logic [7:0] TAG_W = 8'h57;
  localparam logic [7:0] TAG_G = 8'h47;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  typedef enum logic [2:0] {IDLE, TAG, HEX, CR, LF} state_t;
endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: combinational 3-way round-robin, priority starts after last_grant
module rr_arbiter3 (
  input  logic [2:0] pending,
  input  logic [1:0] last_grant,
  output logic [2:0] grant
);
  logic [1:0] first;
  logic [2:0] rot, pick;
  assign first = last_grant >= 2'd2 ? 2'd0 : last_grant + 2'd1;
  // rotate so the highest-priority source sits at bit 0, pick, rotate back
  assign rot = first == 2'd0 ? pending : first == 2'd1 ? {pending[0], pending[2:1]} : {pending[1:0], pending[2]};
  assign pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
  assign grant = first == 2'd0 ? pick : first == 2'd1 ? {pick[1:0], pick[2]} : {pick[0], pick[2:1]};
endmodule

// File: rtl/tx_report_arbiter.sv
// tx_report_arbiter: latches report words from three sources and serialises
// each as an ASCII line (tag, hex digits, CR, LF) to a UART transmitter
module tx_report_arbiter
  import tx_report_arbiter_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [2:0]             req_valid,
  input  logic [3*4*NIBBLES-1:0] req_word,
  output logic [2:0]             req_pending,
  output logic [7:0]             drop_count,
  output logic [7:0]             tx_data,
  output logic                   tx_we,
  input  logic                   tx_busy,
  output logic                   idle
);
  localparam int W = 4 * NIBBLES;
  localparam int DW = $clog2(NIBBLES + 1);
  state_t state, state_nx;
  logic [W-1:0] words [3];
  logic [W-1:0] shift;
  logic [DW-1:0] digit;
  logic [1:0] last_grant, src, g, ndrop;
  logic [2:0] grant, clr, cap, drop;
  logic [8:0] drop_sum;
  logic [3:0] nib;
  logic [7:0] hex, tag;
  logic accept, do_grant, last_digit;
  rr_arbiter3 u_rr (.pending(req_pending), .last_grant(last_grant), .grant(grant));
  assign accept = state != IDLE && !tx_busy;
  assign do_grant = state == IDLE && |req_pending;
  assign g = grant[2] ? 2'd2 : {1'b0, grant[1]};
  assign clr = do_grant ? grant : 3'b000;
  // a strobe landing on its own grant edge refills the slot instead of dropping
  assign cap = req_valid & (~req_pending | clr);
  assign drop = req_valid & req_pending & ~clr;
  assign ndrop = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
  assign drop_sum = {1'b0, drop_count} + {7'b0, ndrop};
  assign last_digit = digit == DW'(NIBBLES - 1);
  assign nib = shift[W-1 -: 4];
  assign hex = nib < 4'd10 ? {4'h0, nib} + 8'd48 : {4'h0, nib} + 8'd55;
  assign tag = src == 2'd0 ? TAG_R : src == 2'd1 ? TAG_W : TAG_G;
  assign tx_we = state != IDLE;
  assign tx_data = state == TAG ? tag : state == HEX ? hex : state == CR ? CHAR_CR : state == LF ? CHAR_LF : 8'h00;
  assign idle = state == IDLE && !(|req_pending);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = do_grant ? TAG : IDLE;
      TAG: state_nx = accept ? HEX : TAG;
      HEX: state_nx = accept && last_digit ? CR : HEX;
      CR: state_nx = accept ? LF : CR;
      LF: state_nx = accept ? IDLE : LF;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      req_pending <= '0;
      drop_count <= '0;
      last_grant <= 2'd2;
      src <= '0;
      shift <= '0;
      digit <= '0;
      for (int i = 0; i < 3; i++) words[i] <= '0;
    end else begin
      state <= state_nx;
      req_pending <= (req_pending & ~clr) | cap;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      for (int i = 0; i < 3; i++) if (cap[i]) words[i] <= req_word[W*i +: W];
      if (do_grant) begin
        shift <= words[g];
        last_grant <= g;
        src <= g;
        digit <= '0;
      end else if (state == HEX && accept) begin
        shift <= shift << 4;
        digit <= digit + 1'b1;
      end
    end
endmodule

// File: tb/tb_tx_report_arbiter.sv
// tb_tx_report_arbiter: table-driven and scoreboard bench for tx_report_arbiter
module tb_tx_report_arbiter;
  localparam int W = 36;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] req_valid = '0;
  logic [3*W-1:0] req_word = '0;
  logic tx_busy = 1'b0;
  logic [2:0] req_pending;
  logic [7:0] drop_count, tx_data;
  logic tx_we, idle;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  typedef struct {
    int         src;
    logic [W-1:0] word;
    logic [7:0] tag;
    logic [7:0] drops;
  } vec_t;
  vec_t vecs[5];

  tx_report_arbiter #(.NIBBLES(9)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_word(req_word),
    .req_pending(req_pending), .drop_count(drop_count), .tx_data(tx_data),
    .tx_we(tx_we), .tx_busy(tx_busy), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // scoreboard: every byte the transmitter accepts must match the queue head
  always @(negedge clock)
    if (reset_n && tx_we && !tx_busy) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte got=%0h want=none", tx_data);
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        check("tx_byte", tx_data, e);
      end
    end

  task automatic push_line(input logic [7:0] tag, input logic [W-1:0] w);
    q.push_back(tag);
    for (int n = 8; n >= 0; n--) begin
      logic [3:0] nib;
      nib = w[4*n +: 4];
      q.push_back(nib < 4'd10 ? {4'h0, nib} + 8'd48 : {4'h0, nib} + 8'd55);
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic strobe(input logic [2:0] m, input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2);
    req_word = {w2, w1, w0};
    req_valid = m;
    @(posedge clock);
    #1;
    req_valid = '0;
  endtask

  task automatic wait_done(input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clock);
      #2;
      ok = q.size() == 0 && idle;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout got=q%0d_idle%0b want=q0_idle1", name, q.size(), idle);
      q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 36'h123456789, 8'h57, 8'd0};
    vecs[1] = '{2, 36'hFEDCBA987, 8'h47, 8'd0};
    vecs[2] = '{0, 36'hFFFFFFFFF, 8'h52, 8'd0};
    vecs[3] = '{1, 36'h000000000, 8'h57, 8'd0};
    vecs[4] = '{2, 36'hA5A5A5A5A, 8'h47, 8'd0};
    #2;
    check("rst_tx_we", tx_we, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_pending", req_pending, 0);
    check("rst_drop", drop_count, 0);
    check("rst_idle", idle, 1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    // exact line and latency for a known word
    foreach (vecs[i]) begin end
    q.push_back(8'h52); q.push_back(8'h30); q.push_back(8'h30); q.push_back(8'h30);
    q.push_back(8'h30); q.push_back(8'h30); q.push_back(8'h32); q.push_back(8'h41);
    q.push_back(8'h33); q.push_back(8'h46); q.push_back(8'h0D); q.push_back(8'h0A);
    strobe(3'b001, 36'h000002A3F, '0, '0);
    @(negedge clock);
    check("lat_pending", req_pending, 3'b001);
    check("lat_we_e0", tx_we, 0);
    @(negedge clock);
    check("lat_we_e1", tx_we, 1);
    check("lat_tag_e1", tx_data, 8'h52);
    repeat (11) @(negedge clock);
    check("lat_lf", tx_data, 8'h0A);
    @(negedge clock);
    check("lat_idle", idle, 1);
    wait_done(5, "line_known");
    for (int i = 0; i < 5; i++) begin
      push_line(vecs[i].tag, vecs[i].word);
      strobe(3'b001 << vecs[i].src, vecs[i].word, vecs[i].word, vecs[i].word);
      wait_done(40, "vec_line");
      check("vec_drop", drop_count, vecs[i].drops);
    end
    // back-pressure mid HEX
    push_line(8'h52, 36'h0123456AB);
    strobe(3'b001, 36'h0123456AB, '0, '0);
    repeat (4) begin @(posedge clock); #1; end
    tx_busy = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("busy_data", tx_data, 8'h32);
      check("busy_we", tx_we, 1);
    end
    @(posedge clock);
    #1;
    tx_busy = 1'b0;
    wait_done(40, "busy_line");
    // simultaneous strobes after reset
    do_reset();
    push_line(8'h52, 36'h111111111);
    push_line(8'h57, 36'h222222222);
    push_line(8'h47, 36'h333333333);
    strobe(3'b111, 36'h111111111, 36'h222222222, 36'h333333333);
    wait_done(100, "three_lines");
    check("three_drop", drop_count, 0);
    // overflow counting with the transmitter stalled
    do_reset();
    tx_busy = 1'b1;
    push_line(8'h52, 36'hABCDEF012);
    strobe(3'b001, 36'hABCDEF012, '0, '0);
    @(posedge clock);
    #1;
    push_line(8'h57, 36'h987654321);
    strobe(3'b010, '0, 36'h987654321, '0);
    strobe(3'b010, '0, 36'h555555555, '0);
    @(negedge clock);
    check("drop_one", drop_count, 1);
    check("drop_pending", req_pending, 3'b010);
    @(posedge clock);
    #1;
    req_valid = 3'b010;
    repeat (300) @(posedge clock);
    #1;
    req_valid = '0;
    @(negedge clock);
    check("drop_sat", drop_count, 255);
    @(posedge clock);
    #1;
    tx_busy = 1'b0;
    wait_done(100, "drop_lines");
    check("drop_clear", req_pending, 0);
    // strobe on its own grant edge
    do_reset();
    push_line(8'h47, 36'h0000000C1);
    push_line(8'h47, 36'h0000000C2);
    strobe(3'b100, '0, '0, 36'h0000000C1);
    strobe(3'b100, '0, '0, 36'h0000000C2);
    @(negedge clock);
    check("grant_edge_pending", req_pending, 3'b100);
    check("grant_edge_drop", drop_count, 0);
    @(posedge clock);
    #1;
    wait_done(100, "grant_edge_lines");
    // reset mid HEX abandons the line
    push_line(8'h52, 36'h13579BDF0);
    strobe(3'b001, 36'h13579BDF0, '0, '0);
    repeat (4) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", tx_we, 0);
    check("mid_rst_pending", req_pending, 0);
    check("mid_rst_idle", idle, 1);
    q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    push_line(8'h57, 36'h2468ACE13);
    strobe(3'b010, '0, 36'h2468ACE13, '0);
    wait_done(40, "post_rst_line");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
